// File: rtl/gpr_wr_arbiter_pkg.sv
// Shared CPU constants and helpers for the GPR write-port arbiter.
// Mirrors the cpu.h widths and active-low enable encoding.
package gpr_wr_arbiter_pkg;

    localparam int CPU_REG_ADDR_W  = 5;
    localparam int CPU_REG_NUM     = 32;
    localparam int CPU_WORD_DATA_W = 32;

    localparam logic CPU_ENABLE_N  = 1'b0;
    localparam logic CPU_DISABLE_N = 1'b1;

    function automatic int rr_next(input int w, input int n);
        return (w + 1) % n;
    endfunction

endpackage

// File: rtl/gpr_wr_arbiter_pick.sv
// Combinational one-hot picker: first valid source at or after ptr_i.
// A constant zero pointer gives plain fixed priority.
module gpr_arb_pick
    import gpr_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (((int'(ptr_i) + k) % NREQ) == j
                    && valid_i[j] && !found) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// GPR write-port arbiter with registered write and busy scoreboard.
// Define GPR_ARB_RR_EN for round-robin instead of fixed priority.
module gpr_wr_arbiter
    import gpr_wr_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int REG_NUM = CPU_REG_NUM,
    parameter int AW      = CPU_REG_ADDR_W,
    parameter int DW      = CPU_WORD_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    chk_addr_0,
    input  logic [AW-1:0]    chk_addr_1,
    output logic             chk_busy_0,
    output logic             chk_busy_1,
    output logic             we_n,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    logic [NREQ-1:0]    gnt;
    logic [PW-1:0]      ptr;
    logic               xfer;
    logic [AW-1:0]      win_addr;
    logic [DW-1:0]      win_data;
    logic               we_n_q;
    logic [AW-1:0]      wr_addr_q;
    logic [DW-1:0]      wr_data_q;
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

`ifdef GPR_ARB_RR_EN
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;

    assign ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && gnt[i]) begin
                rr_ptr_d = PW'(rr_next(i, NREQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign ptr = '0;
`endif

    gpr_arb_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr),
        .gnt_o   (gnt)
    );

    assign req_ready = reset ? '0 : gnt;
    assign xfer      = |req_ready;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // A new reservation outranks the retiring write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[win_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_n_q    <= CPU_DISABLE_N;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            we_n_q <= xfer ? CPU_ENABLE_N : CPU_DISABLE_N;
            if (xfer) begin
                wr_addr_q <= win_addr;
                wr_data_q <= win_data;
            end
            busy_q <= busy_d;
        end
    end

    assign we_n    = reset ? CPU_DISABLE_N : we_n_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    assign chk_busy_0 = busy_q[chk_addr_0]
        & ~(we_n == CPU_ENABLE_N && wr_addr_q == chk_addr_0);
    assign chk_busy_1 = busy_q[chk_addr_1]
        & ~(we_n == CPU_ENABLE_N && wr_addr_q == chk_addr_1);

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Bench for gpr_wr_arbiter: directed vector table plus random model check.
// Expectations follow GPR_ARB_RR_EN when it is defined.
module tb_gpr_wr_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

`ifdef GPR_ARB_RR_EN
    localparam logic [2:0]  G1 = 3'b001, G2 = 3'b010, G3 = 3'b100;
    localparam logic [4:0]  WA2 = 5'd11, WA3 = 5'd12;
    localparam logic [31:0] WD2 = 32'd101, WD3 = 32'd102;
`else
    localparam logic [2:0]  G1 = 3'b001, G2 = 3'b001, G3 = 3'b001;
    localparam logic [4:0]  WA2 = 5'd10, WA3 = 5'd10;
    localparam logic [31:0] WD2 = 32'd100, WD3 = 32'd100;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic [AW-1:0] chk_addr_0;
    logic [AW-1:0] chk_addr_1;
    logic          chk_busy_0;
    logic          chk_busy_1;
    logic          we_n;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    gpr_wr_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .chk_addr_0 (chk_addr_0),
        .chk_addr_1 (chk_addr_1),
        .chk_busy_0 (chk_busy_0),
        .chk_busy_1 (chk_busy_1),
        .we_n       (we_n),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] v,
                         input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2,
                         input logic rv, input logic [4:0] ra,
                         input logic [4:0] c0, c1);
        reset      = r;
        req_valid  = v;
        req_addr   = {a2, a1, a0};
        req_data   = {d2, d1, d0};
        rsv_valid  = rv;
        rsv_addr   = ra;
        chk_addr_0 = c0;
        chk_addr_1 = c1;
    endtask

    // Source i presents addr a+i and data d+i.
    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        rv;
        logic [4:0]  ra;
        logic [4:0]  c0, c1;
        logic [2:0]  rdy;
        logic        wen;
        logic        cw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cb;
        logic        b0, b1;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [2:0] v, input logic [4:0] a,
        input logic [31:0] d, input logic rv, input logic [4:0] ra,
        input logic [4:0] c0, c1, input logic [2:0] rdy,
        input logic wen, cw, input logic [4:0] wa,
        input logic [31:0] wd, input logic cb, b0, b1);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.d = d;
        t.rv = rv; t.ra = ra; t.c0 = c0; t.c1 = c1;
        t.rdy = rdy; t.wen = wen; t.cw = cw; t.wa = wa;
        t.wd = wd; t.cb = cb; t.b0 = b0; t.b1 = b1;
        return t;
    endfunction

    vec_t vt[$];

    bit          m_wen;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit [31:0]   m_busy;
    int          m_ptr;
    bit          pend[N];
    logic [4:0]  sa[N];
    logic [31:0] sd[N];

    initial begin
        drive(1'b1, 3'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
              1'b0, 5'd0, 5'd0, 5'd0);

        // reset, single write
        vt.push_back(mk(1, 3'b111, 0, 0, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 3'b111, 0, 0, 0, 0, 0, 1, 3'b000, 1, 1, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 3'b010, 4, 32'hDEADBEEE, 0, 0, 5, 0,
                        3'b010, 1, 1, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 5, 0,
                        3'b000, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 5, 0,
                        3'b000, 1, 1, 5, 32'hDEADBEEF, 1, 0, 0));
        // contention after a fresh reset
        vt.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 3'b111, 10, 100, 0, 0, 0, 0, G1, 1, 1, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 3'b111, 10, 100, 0, 0, 0, 0, G2, 0, 1, 10, 100, 1, 0, 0));
        vt.push_back(mk(0, 3'b111, 10, 100, 0, 0, 0, 0, G3, 0, 1, WA2, WD2, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, WA3, WD3, 1, 0, 0));
        // scoreboard reserve then clear
        vt.push_back(mk(0, 3'b000, 0, 0, 1, 7, 7, 10, 3'b000, 1, 1, WA3, WD3, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 7, 7, 3'b000, 1, 1, WA3, WD3, 1, 1, 1));
        vt.push_back(mk(0, 3'b001, 7, 32'h77, 0, 0, 7, 7, 3'b001, 1, 1, WA3, WD3, 1, 1, 1));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 7, 8, 3'b000, 0, 1, 7, 32'h77, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 7, 7, 3'b000, 1, 1, 7, 32'h77, 1, 0, 0));
        // reserve and write same register in one cycle
        vt.push_back(mk(0, 3'b001, 9, 32'h99, 1, 9, 9, 7, 3'b001, 1, 1, 7, 32'h77, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 9, 9, 3'b000, 0, 1, 9, 32'h99, 1, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 9, 7, 3'b000, 1, 1, 9, 32'h99, 1, 1, 0));
        // reset lands on the write cycle
        vt.push_back(mk(0, 3'b010, 19, 32'h200, 0, 0, 9, 20, 3'b010, 1, 1, 9, 32'h99, 1, 1, 0));
        vt.push_back(mk(1, 3'b000, 0, 0, 0, 0, 9, 20, 3'b000, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 0, 9, 20, 3'b000, 1, 1, 0, 0, 1, 0, 0));

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].v,
                  vt[i].a, vt[i].a + 5'd1, vt[i].a + 5'd2,
                  vt[i].d, vt[i].d + 32'd1, vt[i].d + 32'd2,
                  vt[i].rv, vt[i].ra, vt[i].c0, vt[i].c1);
            #1;
            check($sformatf("v%0d ready", i), 32'(req_ready), 32'(vt[i].rdy));
            check($sformatf("v%0d we_n", i), 32'(we_n), 32'(vt[i].wen));
            if (vt[i].cw) begin
                check($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vt[i].wa));
                check($sformatf("v%0d wr_data", i), wr_data, vt[i].wd);
            end
            if (vt[i].cb) begin
                check($sformatf("v%0d busy0", i), 32'(chk_busy_0), 32'(vt[i].b0));
                check($sformatf("v%0d busy1", i), 32'(chk_busy_1), 32'(vt[i].b1));
            end
        end

        // random traffic against a reference model; state matches post-reset
        m_wen  = 1'b1;
        m_wa   = '0;
        m_wd   = '0;
        m_busy = '0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            sa[i]   = '0;
            sd[i]   = '0;
        end

        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic       r, rv;
            logic [4:0] ra, c0, c1;
            logic [2:0] erdy;
            bit         ewen, eb0, eb1;
            int         g;

            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    sa[i]   = 5'($urandom_range(7, 0));
                    sd[i]   = $urandom;
                end
            end
            r  = ($urandom_range(99, 0) == 0);
            rv = ($urandom_range(2, 0) == 0);
            ra = 5'($urandom_range(7, 0));
            c0 = 5'($urandom_range(7, 0));
            c1 = 5'($urandom_range(7, 0));

            @(negedge clk);
            drive(r, {pend[2], pend[1], pend[0]},
                  sa[0], sa[1], sa[2], sd[0], sd[1], sd[2],
                  rv, ra, c0, c1);
            #1;

            g = -1;
            if (!r) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            erdy = (g < 0) ? 3'b000 : 3'(1 << g);
            ewen = r ? 1'b1 : m_wen;
            eb0  = m_busy[c0] && !(ewen == 1'b0 && m_wa == c0);
            eb1  = m_busy[c1] && !(ewen == 1'b0 && m_wa == c1);

            check("rnd ready", 32'(req_ready), 32'(erdy));
            check("rnd we_n", 32'(we_n), 32'(ewen));
            check("rnd wr_addr", 32'(wr_addr), 32'(m_wa));
            check("rnd wr_data", wr_data, m_wd);
            check("rnd busy0", 32'(chk_busy_0), 32'(eb0));
            check("rnd busy1", 32'(chk_busy_1), 32'(eb1));

            @(posedge clk);
            if (r) begin
                m_wen  = 1'b1;
                m_wa   = '0;
                m_wd   = '0;
                m_busy = '0;
                m_ptr  = 0;
            end else begin
                if (g >= 0) begin
                    m_wen          = 1'b0;
                    m_wa           = sa[g];
                    m_wd           = sd[g];
                    m_busy[sa[g]]  = 1'b0;
                    pend[g]        = 1'b0;
`ifdef GPR_ARB_RR_EN
                    m_ptr = (g + 1) % N;
`endif
                end else begin
                    m_wen = 1'b1;
                end
                if (rv) m_busy[ra] = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
